// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word addresses to a 1-cycle synchronous ROM
// and buffers responses in a 2-entry FIFO whose head registers drive the out_* port.
module fetch_unit #(
  parameter logic [29:0] RESET_PC = 30'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [29:0] imem_pc,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [29:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [29:0] out_pc,
  input  logic        out_ready
);

  logic [29:0] pc_q;
  logic        inflight;
  logic [29:0] infl_pc;

  // Entry 0 is always the head, so out_* come straight from flops.
  logic [29:0] pc0, pc1;
  logic [31:0] inst0, inst1;
  logic [1:0]  count;

  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occ;

  assign imem_pc   = pc_q;
  assign out_valid = (count != 2'd0);
  assign out_pc    = pc0;
  assign out_inst  = inst0;

  assign pop   = out_valid & out_ready;
  assign push  = inflight & ~redirect_valid;
  assign occ   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue = ~redirect_valid & (occ < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      inflight <= 1'b0;
      infl_pc  <= 30'h0;
      count    <= 2'd0;
      pc0      <= 30'h0;
      pc1      <= 30'h0;
      inst0    <= 32'h0;
      inst1    <= 32'h0;
    end else if (redirect_valid) begin
      // A pop this cycle completes simply by dropping everything afterwards.
      pc_q     <= redirect_pc;
      inflight <= 1'b0;
      count    <= 2'd0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc_q    <= pc_q + 30'd1;
        infl_pc <= pc_q;
      end
      case ({push, pop})
        2'b11: begin
          if (count == 2'd2) begin
            pc0   <= pc1;
            inst0 <= inst1;
            pc1   <= infl_pc;
            inst1 <= imem_inst;
          end else begin
            pc0   <= infl_pc;
            inst0 <= imem_inst;
          end
        end
        2'b01: begin
          pc0   <= pc1;
          inst0 <= inst1;
          count <= count - 2'd1;
        end
        2'b10: begin
          if (count == 2'd0) begin
            pc0   <= infl_pc;
            inst0 <= imem_inst;
          end else begin
            pc1   <= infl_pc;
            inst1 <= imem_inst;
          end
          count <= count + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: startup, backpressure, redirects, reset pulse,
// plus a second instance started near the top of the address space to cover wrap.
module tb_fetch_unit;

  localparam logic [29:0] WRAP_PC = 30'h3FFFFFFE;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] imem_pc;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [29:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [29:0] out_pc;
  logic        out_ready;
  logic [31:0] rom_xor;

  logic [29:0] imem_pc_w;
  logic [31:0] imem_inst_w;
  logic        out_valid_w;
  logic [31:0] out_inst_w;
  logic [29:0] out_pc_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(30'h0)) dut (
    .clk(clk), .rst(rst), .imem_pc(imem_pc), .imem_inst(imem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .out_ready(out_ready)
  );

  fetch_unit #(.RESET_PC(WRAP_PC)) dut_wrap (
    .clk(clk), .rst(rst), .imem_pc(imem_pc_w), .imem_inst(imem_inst_w),
    .redirect_valid(1'b0), .redirect_pc(30'h0),
    .out_valid(out_valid_w), .out_inst(out_inst_w), .out_pc(out_pc_w), .out_ready(1'b1)
  );

  // Synchronous ROMs: word i holds i, optionally xor-scrambled to tell inst from pc.
  always @(posedge clk) begin
    imem_inst   <= {2'b00, imem_pc} ^ rom_xor;
    imem_inst_w <= {2'b00, imem_pc_w};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [29:0] wexp;
    rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 30'h0; rom_xor = 32'h0;
    step(); step(); step();
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_pc", {2'b00, out_pc}, 32'h0);
    check("rst_inst", out_inst, 32'h0);
    check("rst_imem_pc", {2'b00, imem_pc}, 32'h0);
    check("rst_wrap_imem_pc", {2'b00, imem_pc_w}, {2'b00, WRAP_PC});

    // Startup stream: first word two cycles after rst falls.
    rst = 1'b0;
    step();
    check("start_valid_lo", {31'h0, out_valid}, 32'h0);
    check("start_imem_pc", {2'b00, imem_pc}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      step();
      wexp = WRAP_PC + 30'(i);
      check("stream_valid", {31'h0, out_valid}, 32'h1);
      check("stream_pc", {2'b00, out_pc}, i);
      check("stream_inst", out_inst, i);
      check("wrap_pc", {2'b00, out_pc_w}, {2'b00, wexp});
    end

    // Backpressure from out_pc=4 for five cycles.
    step();
    check("bp_head", {2'b00, out_pc}, 32'h4);
    out_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      check("bp_hold_pc", {2'b00, out_pc}, 32'h4);
      check("bp_hold_inst", out_inst, 32'h4);
      check("bp_imem_pc", {2'b00, imem_pc}, 32'h6);
      step();
    end
    out_ready = 1'b1;
    check("bp_release_pc", {2'b00, out_pc}, 32'h4);
    for (int k = 5; k < 8; k++) begin
      step();
      check("bp_after_valid", {31'h0, out_valid}, 32'h1);
      check("bp_after_pc", {2'b00, out_pc}, k);
    end

    // Redirect while streaming; new stream uses scrambled ROM data.
    redirect_valid = 1'b1; redirect_pc = 30'h100; rom_xor = 32'hA500_0000;
    step();
    redirect_valid = 1'b0;
    check("rd_t1_valid", {31'h0, out_valid}, 32'h0);
    check("rd_t1_imem_pc", {2'b00, imem_pc}, 32'h100);
    step();
    check("rd_t2_valid", {31'h0, out_valid}, 32'h0);
    step();
    check("rd_t3_valid", {31'h0, out_valid}, 32'h1);
    check("rd_t3_pc", {2'b00, out_pc}, 32'h100);
    check("rd_t3_inst", out_inst, 32'hA500_0100);
    step();
    check("rd_t4_pc", {2'b00, out_pc}, 32'h101);
    check("rd_t4_inst", out_inst, 32'hA500_0101);

    // Back-to-back redirects: only the last stream survives.
    redirect_valid = 1'b1; redirect_pc = 30'h200;
    step();
    redirect_pc = 30'h300;
    step();
    redirect_valid = 1'b0;
    check("b2b_valid1", {31'h0, out_valid}, 32'h0);
    step();
    check("b2b_valid2", {31'h0, out_valid}, 32'h0);
    step();
    check("b2b_pc", {2'b00, out_pc}, 32'h300);
    step();
    check("b2b_pc_next", {2'b00, out_pc}, 32'h301);

    // Redirect with a full FIFO under backpressure.
    out_ready = 1'b0;
    step();
    check("full_head", {2'b00, out_pc}, 32'h301);
    check("full_valid", {31'h0, out_valid}, 32'h1);
    redirect_valid = 1'b1; redirect_pc = 30'h40;
    step();
    redirect_valid = 1'b0; out_ready = 1'b1;
    check("full_rd_valid1", {31'h0, out_valid}, 32'h0);
    step();
    check("full_rd_valid2", {31'h0, out_valid}, 32'h0);
    step();
    check("full_rd_pc", {2'b00, out_pc}, 32'h40);
    step();
    check("full_rd_pc_next", {2'b00, out_pc}, 32'h41);

    // One-cycle reset with two buffered entries; reset beats a concurrent redirect.
    out_ready = 1'b0;
    step();
    check("pre_rst_head", {2'b00, out_pc}, 32'h41);
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 30'h77;
    step();
    rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
    check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
    check("mid_rst_imem_pc", {2'b00, imem_pc}, 32'h0);
    check("mid_rst_out_pc", {2'b00, out_pc}, 32'h0);
    step();
    check("post_rst_valid", {31'h0, out_valid}, 32'h0);
    step();
    check("post_rst_pc", {2'b00, out_pc}, 32'h0);
    check("post_rst_inst", out_inst, 32'hA500_0000);
    check("post_rst_valid_hi", {31'h0, out_valid}, 32'h1);
    step();
    check("post_rst_pc1", {2'b00, out_pc}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 30'h0, SHALL be the word address of the first instruction fetched after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 imem_pc  output  30  SHALL be the word address presented to the instruction ROM.
REQ-005 imem_inst  input  32  SHALL be the ROM data for the imem_pc sampled at the previous rising edge (1-cycle synchronous read).
REQ-006 redirect_valid  input  1  SHALL be a request to restart fetch at redirect_pc.
REQ-007 redirect_pc  input  30  SHALL be the word address to restart at.
REQ-008 out_valid  output  1  SHALL be high while out_inst/out_pc hold a valid fetched instruction.
REQ-009 out_inst  output  32  SHALL be the fetched instruction word.
REQ-010 out_pc  output  30  SHALL be the word address of out_inst.
REQ-011 out_ready  input  1  SHALL be high when the consumer accepts out_inst this cycle.

Function
REQ-012 State SHALL be: pc_q (next fetch address), a 1-bit in-flight flag with captured in-flight address, and a 2-entry FIFO of {pc, inst}.
REQ-013 imem_pc SHALL equal pc_q combinationally at all times.
REQ-014 pop SHALL be out_valid & out_ready; a transfer occurs exactly on pop cycles.
REQ-015 issue SHALL be asserted when !redirect_valid and (occupancy + inflight - pop) < 2.
REQ-016 On issue: pc_q <= pc_q + 1 (modulo 2^30, 30'h3FFFFFFF wraps to 0); inflight <= 1; inflight address <= pc_q. Otherwise inflight <= 0 and pc_q holds.
REQ-017 When inflight is 1 and !redirect_valid, {inflight address, imem_inst} SHALL be written into the FIFO at the end of that cycle; issue rules guarantee no overflow.
REQ-018 out_valid SHALL equal FIFO non-empty; out_inst/out_pc SHALL be the FIFO head, registered (no combinational path from imem_inst to out_*).
REQ-019 Simultaneous push and pop SHALL keep occupancy unchanged and preserve order.
REQ-020 With out_ready held high and no redirect, one instruction SHALL be delivered per cycle in consecutive pc order.
REQ-021 While out_valid=1 and out_ready=0, out_inst/out_pc SHALL hold stable.
REQ-022 Latency: an address issued in cycle t SHALL appear on out_* with out_valid=1 in cycle t+2 at the earliest.
REQ-023 On redirect_valid in cycle t: a pop in cycle t SHALL complete normally; then the FIFO SHALL be flushed, the response arriving in cycle t discarded, inflight <= 0, and pc_q <= redirect_pc; no issue occurs in cycle t.
REQ-024 After redirect in cycle t with out_ready=1: redirect_pc SHALL be issued in t+1 and appear on out_* in t+3; out_valid SHALL be 0 in t+1 and t+2.
REQ-025 Back-to-back redirects SHALL each override the previous; only the last one's stream SHALL be delivered.

Reset
REQ-026 While rst=1: pc_q=RESET_PC, inflight=0, FIFO empty, out_valid=0, out_inst=32'h0, out_pc=30'h0; no issue and no capture.
REQ-027 rst SHALL take priority over redirect_valid and out_ready.
REQ-028 rst asserted mid-operation SHALL discard all in-flight and buffered instructions; the first cycle with rst=0 SHALL issue RESET_PC, and out_valid SHALL rise 2 cycles later.

Verification
REQ-029 Reset release, RESET_PC=0, out_ready=1, ROM[i]=i -> out_valid first high 2 cycles after rst falls; out_pc 0,1,2,3... and out_inst 0,1,2,3... on consecutive cycles.
REQ-030 Backpressure: out_ready=0 for 5 cycles from out_pc=4 -> out_pc holds 4, imem_pc stops advancing; on release, 4,5,6 are delivered with none lost or duplicated.
REQ-031 Redirect: redirect_valid=1, redirect_pc=30'h100 in cycle t while streaming -> out_valid=0 in t+1 and t+2, out_pc=30'h100 in t+3, then 30'h101.
REQ-032 Redirect with out_ready=0 and full FIFO -> both entries dropped, next delivered out_pc=redirect_pc.
REQ-033 Wrap: RESET_PC=30'h3FFFFFFE -> out_pc sequence 3FFFFFFE, 3FFFFFFF, 0, 1.
REQ-034 rst pulsed for 1 cycle mid-stream with FIFO holding 2 entries -> out_valid=0 the next cycle, then out_pc=RESET_PC 2 cycles after rst falls.
